dmem_arbiter: RTL and testbench

//   Shares the single data-RAM port between the CPU EX stage and one DMA/debug master.

---
 rtl/dmem_arbiter_pkg.sv | 20 ++
 rtl/dmem_arbiter_rr2.sv | 48 ++++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the data-RAM arbiter.
package dmem_arbiter_pkg;

  localparam int ARB_ADDRBUS   = 32;
  localparam int ARB_DATABUS   = 32;
  localparam int ARB_MAX_BURST = 8;

  // Registered owner encoding, also visible on the owner port.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_CPU  = 2'b01,
    ARB_DMA  = 2'b10
  } arb_state_e;

  // Width of a counter that must hold values 0..max_burst inclusive.
  function automatic int arb_cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// Two-way combinational priority picker between the CPU and the DMA master.
// A lone requester always wins. Under contention the CPU wins from IDLE,
// the DMA wins right after a CPU access, and a DMA burst keeps the port
// until it has used MAX_BURST beats.
module arb_rr2
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_BURST = ARB_MAX_BURST,
  parameter int CNT_W     = arb_cnt_width(ARB_MAX_BURST)
) (
  input  arb_state_e       state_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             cpu_req_i,
  input  logic             dma_req_i,
  output logic             cpu_gnt_o,
  output logic             dma_gnt_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  // Grant selection from requests, current owner and burst length.
  always_comb begin
    cpu_gnt_o = 1'b0;
    dma_gnt_o = 1'b0;
    if (cpu_req_i && dma_req_i) begin
      case (state_i)
        ARB_IDLE: cpu_gnt_o = 1'b1;
        ARB_CPU:  dma_gnt_o = 1'b1;
        ARB_DMA: begin
          if (cnt_i < MAX_CNT) begin
            dma_gnt_o = 1'b1;
          end else begin
            cpu_gnt_o = 1'b1;
          end
        end
        default:  cpu_gnt_o = 1'b1;
      endcase
    end else if (cpu_req_i) begin
      cpu_gnt_o = 1'b1;
    end else if (dma_req_i) begin
      dma_gnt_o = 1'b1;
    end else begin
      cpu_gnt_o = 1'b0;
      dma_gnt_o = 1'b0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-RAM port between the CPU EX stage and a DMA/debug
// master. Grants are combinational so every access completes in the cycle it
// is granted; cpu_hold freezes the pipeline while the CPU is waiting.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = ARB_ADDRBUS,
  parameter int DATA_W    = ARB_DATABUS,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_hold,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        owner
);

  localparam int               CNT_W   = arb_cnt_width(MAX_BURST);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             pick_cpu_s, pick_dma_s;
  logic             cpu_gnt_s, dma_gnt_s;

  arb_rr2 #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_rr2 (
    .state_i   (state_q),
    .cnt_i     (burst_cnt_q),
    .cpu_req_i (cpu_req),
    .dma_req_i (dma_req),
    .cpu_gnt_o (pick_cpu_s),
    .dma_gnt_o (pick_dma_s)
  );

  // While reset is asserted no master may touch the RAM, even mid-burst.
  always_comb begin
    cpu_gnt_s = pick_cpu_s & rst_n;
    dma_gnt_s = pick_dma_s & rst_n;
  end

  // Next owner and burst length; any cycle without a DMA beat clears the count.
  always_comb begin
    state_d     = ARB_IDLE;
    burst_cnt_d = '0;
    if (dma_gnt_s) begin
      state_d = ARB_DMA;
      if (state_q == ARB_DMA) begin
        if (burst_cnt_q == MAX_CNT) begin
          burst_cnt_d = MAX_CNT;
        end else begin
          burst_cnt_d = burst_cnt_q + ONE_CNT;
        end
      end else begin
        burst_cnt_d = ONE_CNT;
      end
    end else if (cpu_gnt_s) begin
      state_d     = ARB_CPU;
      burst_cnt_d = '0;
    end else begin
      state_d     = ARB_IDLE;
      burst_cnt_d = '0;
    end
  end

  // Owner/burst state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // RAM-side mux, handshake outputs and read-data return paths.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    cpu_rdata = '0;
    dma_rdata = '0;
    if (cpu_gnt_s) begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
      cpu_rdata = ram_rdata;
    end else if (dma_gnt_s) begin
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
      ram_we    = dma_we;
      dma_rdata = ram_rdata;
    end else begin
      ram_addr  = '0;
      ram_wdata = '0;
      ram_we    = 1'b0;
    end
    cpu_hold = cpu_req & ~cpu_gnt_s & rst_n;
    dma_gnt  = dma_gnt_s;
    owner    = state_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, ram_rdata;
  logic [31:0] cpu_rdata, dma_rdata, ram_addr, ram_wdata;
  logic        cpu_hold, dma_gnt, ram_we;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_gnt(dma_gnt),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic drop_all();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    ram_rdata = 32'h0;
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drop_all();
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; dma_req = 1'b1; dma_we = 1'b1;
    cpu_addr = 32'h4; dma_addr = 32'h8;
    #2;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %b exp 0", ram_we); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_cpu_hold got %b exp 0", cpu_hold); end
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_dma_gnt got %b exp 0", dma_gnt); end
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL reset_owner got %b exp 00", owner); end
    next_cycle();
    drop_all();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_cpu_store();
    drop_all();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hA5;
    #1;
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL cpu_store_we got %b exp 1", ram_we); end
    checks++; if (ram_addr !== 32'h10) begin errors++; $display("FAIL cpu_store_addr got %h exp 10", ram_addr); end
    checks++; if (ram_wdata !== 32'hA5) begin errors++; $display("FAIL cpu_store_wdata got %h exp a5", ram_wdata); end
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL cpu_store_hold got %b exp 0", cpu_hold); end
    next_cycle();
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL cpu_store_owner got %b exp 01", owner); end
    drop_all();
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL idle_we got %b exp 0", ram_we); end
    next_cycle();
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL idle_owner got %b exp 00", owner); end
  endtask

  task automatic test_dma_burst();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'h40 + 32'(i * 4);
      drop_all();
      dma_req = 1'b1; dma_we = 1'b1; dma_addr = a; dma_wdata = 32'h100 + 32'(i);
      #1;
      checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL burst_gnt beat %0d got %b exp 1", i, dma_gnt); end
      checks++; if (ram_addr !== a) begin errors++; $display("FAIL burst_addr beat %0d got %h exp %h", i, ram_addr, a); end
      checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL burst_we beat %0d got %b exp 1", i, ram_we); end
      next_cycle();
      checks++; if (owner !== 2'b10) begin errors++; $display("FAIL burst_owner beat %0d got %b exp 10", i, owner); end
      checks++; if (dut.burst_cnt_q !== 4'(i + 1)) begin errors++; $display("FAIL burst_cnt beat %0d got %0d exp %0d", i, dut.burst_cnt_q, i + 1); end
    end
    drop_all();
    next_cycle();
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL burst_end_owner got %b exp 00", owner); end
    checks++; if (dut.burst_cnt_q !== 4'd0) begin errors++; $display("FAIL burst_end_cnt got %0d exp 0", dut.burst_cnt_q); end
  endtask

  task automatic test_contention();
    logic exp_cpu;
    drop_all();
    cpu_req = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'h11;
    dma_req = 1'b1; dma_addr = 32'h300; dma_wdata = 32'h22;
    for (int c = 0; c <= 10; c++) begin
      exp_cpu = (c == 0) || (c == 9);
      #1;
      checks++; if (cpu_hold !== !exp_cpu) begin errors++; $display("FAIL contend_hold cycle %0d got %b exp %b", c, cpu_hold, !exp_cpu); end
      checks++; if (dma_gnt !== !exp_cpu) begin errors++; $display("FAIL contend_gnt cycle %0d got %b exp %b", c, dma_gnt, !exp_cpu); end
      checks++; if (ram_addr !== (exp_cpu ? 32'h200 : 32'h300)) begin errors++; $display("FAIL contend_addr cycle %0d got %h", c, ram_addr); end
      next_cycle();
    end
    drop_all();
    next_cycle();
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL contend_end_owner got %b exp 00", owner); end
  endtask

  task automatic test_dma_read();
    drop_all();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20; ram_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL dread_gnt got %b exp 1", dma_gnt); end
    checks++; if (dma_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dread_rdata got %h exp deadbeef", dma_rdata); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL dread_cpu_rdata got %h exp 0", cpu_rdata); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL dread_we got %b exp 0", ram_we); end
    next_cycle();
    drop_all();
    cpu_req = 1'b1; cpu_addr = 32'h24; ram_rdata = 32'h12345678;
    #1;
    checks++; if (cpu_rdata !== 32'h12345678) begin errors++; $display("FAIL cread_rdata got %h exp 12345678", cpu_rdata); end
    checks++; if (dma_rdata !== 32'h0) begin errors++; $display("FAIL cread_dma_rdata got %h exp 0", dma_rdata); end
    next_cycle();
    drop_all();
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    drop_all();
    cpu_req = 1'b1; cpu_addr = 32'h500;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h600;
    // cycle 0 CPU, cycles 1..2 DMA beats 1..2
    for (int c = 0; c < 3; c++) next_cycle();
    #1;
    checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL rst_mid_beat3_gnt got %b exp 1", dma_gnt); end
    rst_n = 1'b0;
    #1;
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL rst_mid_gnt got %b exp 0", dma_gnt); end
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_mid_we got %b exp 0", ram_we); end
    checks++; if (owner !== 2'b00) begin errors++; $display("FAIL rst_mid_owner got %b exp 00", owner); end
    next_cycle();
    rst_n = 1'b1;
    #1;
    checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL rst_rel_hold got %b exp 0", cpu_hold); end
    checks++; if (ram_addr !== 32'h500) begin errors++; $display("FAIL rst_rel_addr got %h exp 500", ram_addr); end
    checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL rst_rel_gnt got %b exp 0", dma_gnt); end
    next_cycle();
    checks++; if (owner !== 2'b01) begin errors++; $display("FAIL rst_rel_owner got %b exp 01", owner); end
    drop_all();
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_cpu_store();
    test_dma_burst();
    test_contention();
    test_dma_read();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
